tc_gpio_pad_ctrl: RTL and testbench
===================================

TC_GPIO_PAD_CTRL -- requirements
Module: tc_gpio_pad_ctrl

Interface
REQ-001 The block SHALL have parameter NumPads, default 8, giving the number of controlled digital pads.
REQ-002 The block SHALL have parameter DebounceW, default 8, giving the debounce counter width.
REQ-003 The block SHALL use one clock and a synchronous active-high reset: clk_i  in  1  rising-edge clock.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 out_wdata_i  in  NumPads  output values to drive.
REQ-006 out_we_i  in  1  write strobe for out_wdata_i.
REQ-007 dir_out_i  in  NumPads  1 = pad driven by chip, 0 = input.
REQ-008 drv_strength_i  in  4*NumPads  per-pad drive strength, 4 bits per pad.
REQ-009 pullup_en_i, pulldown_en_i  in  NumPads each  requested pull enables.
REQ-010 debounce_cycles_i  in  DebounceW  stable-cycle count D before an input change is accepted.
REQ-011 irq_rise_en_i, irq_fall_en_i  in  NumPads each  edge interrupt enables.
REQ-012 irq_clear_i  in  NumPads  one-cycle clear pulse per pending bit.
REQ-013 pad_data_o  out  NumPads  to the IO cell data input.
REQ-014 pad_oe_no  out  NumPads  to the IO cell active-low output enable.
REQ-015 pad_drv_o  out  4*NumPads  to the IO cell drive strength.
REQ-016 pad_pu_en_o, pad_pd_en_o  out  NumPads each  to the IO cell pull enables.
REQ-017 pad_data_i  in  NumPads  from the IO cell data output, asynchronous to clk_i.
REQ-018 in_data_o  out  NumPads  synchronized, filtered pad value.
REQ-019 irq_pending_o  out  NumPads  latched edge events; irq_o  out  1  OR of irq_pending_o.

Function
REQ-020 pad_data_o SHALL load out_wdata_i on the edge where out_we_i=1 and hold it otherwise.
REQ-021 pad_oe_no, pad_drv_o, pad_pu_en_o and pad_pd_en_o SHALL be registered from their inputs every cycle, with 1-cycle latency; pad_oe_no = ~dir_out_i.
REQ-022 If pullup_en_i and pulldown_en_i are both 1 for a pad, both pad pull outputs SHALL be 0.
REQ-023 pad_data_i SHALL pass through a 2-flop synchronizer (sync1, sync2) per pad, regardless of direction, so output pads read back.
REQ-024 Per pad, the counter SHALL increment each cycle sync2 != filt and clear when sync2 == filt or when filt updates.
REQ-025 filt SHALL take sync2 on the edge where sync2 != filt and counter == D.
REQ-026 The resulting latency from a stable pad change to in_data_o SHALL be 3+D cycles; D=0 gives 3 cycles.
REQ-027 A glitch shorter than D+1 sampled cycles SHALL NOT change in_data_o.
REQ-028 The counter SHALL saturate at 2^DebounceW-1 without wrapping.
REQ-029 On the same edge filt updates 0->1 (1->0), irq_pending_o SHALL set if irq_rise_en_i (irq_fall_en_i) is 1 for that pad.
REQ-030 Pending SHALL clear on irq_clear_i; on simultaneous set and clear, set SHALL win.
REQ-031 irq_o SHALL be the combinational OR of the pending registers.
REQ-032 A change of debounce_cycles_i mid-count SHALL take effect on the next comparison, with no counter reset.

Reset
REQ-033 While rst_i=1, at a clock edge: pad_data_o=0, pad_oe_no=all 1 (all pads inputs), pad_drv_o=0, pulls=0, sync1/sync2/filt/in_data_o=0, counters=0, pending=0.
REQ-034 Reset asserted mid-debounce SHALL discard the partial count; after release, a high pad SHALL reach in_data_o in 3+D cycles with no interrupt unless rise is enabled.

Configuration
REQ-035 With TC_GPIO_DEBOUNCE_EN defined, the debounce counters SHALL be built as specified in REQ-024 to REQ-032.
REQ-036 Without TC_GPIO_DEBOUNCE_EN, counters SHALL NOT be built; debounce_cycles_i stays a port but is ignored, and behaviour equals D=0 (3-cycle latency).

Structure
REQ-037 Package tc_gpio_pkg SHALL hold the drive-strength width constant (4) and the per-pad config struct (dir, drv, pu, pd).
REQ-038 Sub-module tc_gpio_in_filter SHALL implement one pad's synchronizer, debounce counter, filt register and rise/fall pulse outputs, instantiated NumPads times.

Verification
REQ-039 Reset check: assert rst_i with random inputs -> pad_oe_no=8'hFF, pad_data_o=0, irq_o=0 one cycle later.
REQ-040 Output path: dir_out_i=8'h0F, out_we_i pulse with 8'hA5 -> next cycle pad_data_o=8'hA5, pad_oe_no=8'hF0.
REQ-041 Debounce: D=4, pad0 stable 0->1 -> in_data_o[0] rises exactly 7 cycles later; 3-cycle pulse -> no change.
REQ-042 IRQ: irq_rise_en_i[2]=1, irq_fall_en_i[2]=0, D=0, pad2 0->1->0 -> pending[2] set at rise only; irq_clear_i[2] pulse clears; set+clear in same cycle -> remains set.
REQ-043 Pull conflict: pullup_en_i[5]=pulldown_en_i[5]=1 -> pad_pu_en_o[5]=pad_pd_en_o[5]=0.
REQ-044 Macro off: build without TC_GPIO_DEBOUNCE_EN, D=200 -> 3-cycle latency.

Source files
------------

// File: rtl/tc_gpio_pkg.sv
// Shared constants and types for the GPIO pad controller.
// Debounce counters are built only when TC_GPIO_DEBOUNCE_EN is defined.
package tc_gpio_pkg;

    localparam int DrvW = 4;

    typedef struct packed {
        logic            dir;
        logic [DrvW-1:0] drv;
        logic            pu;
        logic            pd;
    } pad_cfg_t;

endpackage

// File: rtl/tc_gpio_pad_ctrl_if.sv
// IO-cell side bundle of the GPIO pad controller: controller drives the cell
// controls (master) and the cell returns the raw pad level (slave side).
interface tc_gpio_pad_ctrl_if
    import tc_gpio_pkg::*;
#(
    parameter int NumPads = 8
);
    logic [NumPads-1:0]      pad_data;
    logic [NumPads-1:0]      pad_oe_n;
    logic [DrvW*NumPads-1:0] pad_drv;
    logic [NumPads-1:0]      pad_pu_en;
    logic [NumPads-1:0]      pad_pd_en;
    logic [NumPads-1:0]      pad_in;

    modport master (
        output pad_data, pad_oe_n, pad_drv, pad_pu_en, pad_pd_en,
        input  pad_in
    );

    modport slave (
        input  pad_data, pad_oe_n, pad_drv, pad_pu_en, pad_pd_en,
        output pad_in
    );
endinterface

// File: rtl/tc_gpio_in_filter.sv
// One pad's input path: 2-flop synchronizer, optional debounce counter
// (TC_GPIO_DEBOUNCE_EN), filtered level register and edge pulses.
module tc_gpio_in_filter
    import tc_gpio_pkg::*;
#(
    parameter int DebounceW = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pad_i,
    input  logic [DebounceW-1:0] debounce_cycles_i,
    output logic                 filt_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic filt_q;
    logic filt_d;
    logic upd_s;

`ifdef TC_GPIO_DEBOUNCE_EN
    localparam logic [DebounceW-1:0] CntOne = {{(DebounceW-1){1'b0}}, 1'b1};

    logic [DebounceW-1:0] cnt_q;
    logic [DebounceW-1:0] cnt_d;

    // Count cycles of disagreement; >= keeps a lowered threshold from stranding a saturated count.
    always_comb begin
        cnt_d = '0;
        upd_s = 1'b0;
        if (sync2_q != filt_q) begin
            if (cnt_q >= debounce_cycles_i) begin
                upd_s = 1'b1;
            end else if (cnt_q != {DebounceW{1'b1}}) begin
                cnt_d = cnt_q + CntOne;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_dbc_s;
    assign unused_dbc_s = ^debounce_cycles_i;

    // Without debouncing the filtered level follows sync2 immediately.
    always_comb begin
        upd_s = (sync2_q != filt_q);
    end
`endif

    // Next filtered level and one-cycle edge pulses coincident with the update.
    always_comb begin
        filt_d = upd_s ? sync2_q : filt_q;
        rise_o = upd_s & sync2_q;
        fall_o = upd_s & ~sync2_q;
    end

    // Synchronizer and filtered-level registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/tc_gpio_pad_ctrl.sv
// GPIO pad controller: registered IO-cell controls, synchronized/filtered inputs
// and edge interrupts. Debouncing is enabled by defining TC_GPIO_DEBOUNCE_EN.
module tc_gpio_pad_ctrl
    import tc_gpio_pkg::*;
#(
    parameter int NumPads   = 8,
    parameter int DebounceW = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumPads-1:0]        out_wdata_i,
    input  logic                      out_we_i,
    input  logic [NumPads-1:0]        dir_out_i,
    input  logic [DrvW*NumPads-1:0]   drv_strength_i,
    input  logic [NumPads-1:0]        pullup_en_i,
    input  logic [NumPads-1:0]        pulldown_en_i,
    input  logic [DebounceW-1:0]      debounce_cycles_i,
    input  logic [NumPads-1:0]        irq_rise_en_i,
    input  logic [NumPads-1:0]        irq_fall_en_i,
    input  logic [NumPads-1:0]        irq_clear_i,
    output logic [NumPads-1:0]        pad_data_o,
    output logic [NumPads-1:0]        pad_oe_no,
    output logic [DrvW*NumPads-1:0]   pad_drv_o,
    output logic [NumPads-1:0]        pad_pu_en_o,
    output logic [NumPads-1:0]        pad_pd_en_o,
    input  logic [NumPads-1:0]        pad_data_i,
    output logic [NumPads-1:0]        in_data_o,
    output logic [NumPads-1:0]        irq_pending_o,
    output logic                      irq_o
);

    logic [NumPads-1:0] data_q;
    logic [NumPads-1:0] data_d;
    pad_cfg_t           cfg_q [NumPads];
    pad_cfg_t           cfg_d [NumPads];
    logic [NumPads-1:0] pend_q;
    logic [NumPads-1:0] pend_d;
    logic [NumPads-1:0] rise_s;
    logic [NumPads-1:0] fall_s;

    for (genvar g = 0; g < NumPads; g++) begin : g_pad
        tc_gpio_in_filter #(
            .DebounceW (DebounceW)
        ) u_filter (
            .clk_i             (clk_i),
            .rst_i             (rst_i),
            .pad_i             (pad_data_i[g]),
            .debounce_cycles_i (debounce_cycles_i),
            .filt_o            (in_data_o[g]),
            .rise_o            (rise_s[g]),
            .fall_o            (fall_s[g])
        );
    end

    // Next-state for output data, pad config and pending interrupts; conflicting pulls both drop.
    always_comb begin
        data_d = out_we_i ? out_wdata_i : data_q;
        for (int i = 0; i < NumPads; i++) begin
            cfg_d[i].dir = dir_out_i[i];
            cfg_d[i].drv = drv_strength_i[i*DrvW +: DrvW];
            cfg_d[i].pu  = pullup_en_i[i] & ~pulldown_en_i[i];
            cfg_d[i].pd  = pulldown_en_i[i] & ~pullup_en_i[i];
        end
        pend_d = (pend_q & ~irq_clear_i)
               | (rise_s & irq_rise_en_i)
               | (fall_s & irq_fall_en_i);
    end

    // Control, config and pending registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            pend_q <= '0;
            for (int i = 0; i < NumPads; i++) begin
                cfg_q[i] <= '0;
            end
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
            for (int i = 0; i < NumPads; i++) begin
                cfg_q[i] <= cfg_d[i];
            end
        end
    end

    // Unpack registered config onto the IO-cell outputs.
    always_comb begin
        pad_oe_no   = '0;
        pad_drv_o   = '0;
        pad_pu_en_o = '0;
        pad_pd_en_o = '0;
        for (int i = 0; i < NumPads; i++) begin
            pad_oe_no[i]               = ~cfg_q[i].dir;
            pad_drv_o[i*DrvW +: DrvW]  = cfg_q[i].drv;
            pad_pu_en_o[i]             = cfg_q[i].pu;
            pad_pd_en_o[i]             = cfg_q[i].pd;
        end
    end

    assign pad_data_o    = data_q;
    assign irq_pending_o = pend_q;
    assign irq_o         = |pend_q;

endmodule

// File: tb/tb_tc_gpio_pad_ctrl.sv
// Directed self-checking bench for tc_gpio_pad_ctrl; expected input latency
// follows whether TC_GPIO_DEBOUNCE_EN is defined for the build.
module tb_tc_gpio_pad_ctrl;
    import tc_gpio_pkg::*;

    localparam int NP = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   out_wdata, dir_out, pullup_en, pulldown_en;
    logic            out_we;
    logic [4*NP-1:0] drv_strength;
    logic [DW-1:0]   debounce_cycles;
    logic [NP-1:0]   irq_rise_en, irq_fall_en, irq_clear;
    logic [NP-1:0]   in_data, irq_pending;
    logic            irq;

    int chk_cnt  = 0;
    int pass_cnt = 0;

`ifdef TC_GPIO_DEBOUNCE_EN
    localparam bit DbEn = 1'b1;
`else
    localparam bit DbEn = 1'b0;
`endif

    tc_gpio_pad_ctrl_if #(.NumPads(NP)) pad_if ();

    always #5 clk = ~clk;

    tc_gpio_pad_ctrl #(.NumPads(NP), .DebounceW(DW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .out_wdata_i       (out_wdata),
        .out_we_i          (out_we),
        .dir_out_i         (dir_out),
        .drv_strength_i    (drv_strength),
        .pullup_en_i       (pullup_en),
        .pulldown_en_i     (pulldown_en),
        .debounce_cycles_i (debounce_cycles),
        .irq_rise_en_i     (irq_rise_en),
        .irq_fall_en_i     (irq_fall_en),
        .irq_clear_i       (irq_clear),
        .pad_data_o        (pad_if.pad_data),
        .pad_oe_no         (pad_if.pad_oe_n),
        .pad_drv_o         (pad_if.pad_drv),
        .pad_pu_en_o       (pad_if.pad_pu_en),
        .pad_pd_en_o       (pad_if.pad_pd_en),
        .pad_data_i        (pad_if.pad_in),
        .in_data_o         (in_data),
        .irq_pending_o     (irq_pending),
        .irq_o             (irq)
    );

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int lat(input int d);
        return DbEn ? 3 + d : 3;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        out_wdata = $urandom(); out_we = 1'b1; dir_out = $urandom();
        drv_strength = $urandom(); pullup_en = $urandom(); pulldown_en = $urandom();
        debounce_cycles = $urandom(); irq_rise_en = $urandom(); irq_fall_en = $urandom();
        irq_clear = $urandom(); pad_if.pad_in = $urandom();
        step(1);
        chk_cnt++; if (pad_if.pad_oe_n !== 8'hFF) $display("FAIL reset_oe: got %h want ff", pad_if.pad_oe_n); else pass_cnt++;
        chk_cnt++; if (pad_if.pad_data !== 8'h00) $display("FAIL reset_data: got %h want 00", pad_if.pad_data); else pass_cnt++;
        chk_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
        chk_cnt++; if ({pad_if.pad_drv, pad_if.pad_pu_en, pad_if.pad_pd_en, in_data} !== 56'h0)
            $display("FAIL reset_misc: got %h want 0", {pad_if.pad_drv, pad_if.pad_pu_en, pad_if.pad_pd_en, in_data}); else pass_cnt++;
        out_wdata = 8'h00; out_we = 1'b0; dir_out = 8'h00; drv_strength = 32'h0;
        pullup_en = 8'h00; pulldown_en = 8'h00; debounce_cycles = 8'd0;
        irq_rise_en = 8'h00; irq_fall_en = 8'h00; irq_clear = 8'h00; pad_if.pad_in = 8'h00;
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_output;
        dir_out = 8'h0F; out_wdata = 8'hA5; out_we = 1'b1;
        drv_strength = 32'h1234_5678;
        step(1);
        out_we = 1'b0; out_wdata = 8'h3C;
        chk_cnt++; if (pad_if.pad_data !== 8'hA5) $display("FAIL out_data: got %h want a5", pad_if.pad_data); else pass_cnt++;
        chk_cnt++; if (pad_if.pad_oe_n !== 8'hF0) $display("FAIL out_oe: got %h want f0", pad_if.pad_oe_n); else pass_cnt++;
        chk_cnt++; if (pad_if.pad_drv !== 32'h1234_5678) $display("FAIL out_drv: got %h want 12345678", pad_if.pad_drv); else pass_cnt++;
        step(2);
        chk_cnt++; if (pad_if.pad_data !== 8'hA5) $display("FAIL out_hold: got %h want a5", pad_if.pad_data); else pass_cnt++;
    endtask

    task automatic test_pull;
        pullup_en = 8'h21; pulldown_en = 8'h22;
        step(1);
        chk_cnt++; if (pad_if.pad_pu_en !== 8'h01) $display("FAIL pull_pu: got %h want 01", pad_if.pad_pu_en); else pass_cnt++;
        chk_cnt++; if (pad_if.pad_pd_en !== 8'h02) $display("FAIL pull_pd: got %h want 02", pad_if.pad_pd_en); else pass_cnt++;
        pullup_en = 8'h00; pulldown_en = 8'h00;
        step(1);
    endtask

    task automatic test_debounce;
        logic exp;
        debounce_cycles = 8'd4;
        pad_if.pad_in[0] = 1'b1;
        step(lat(4) - 1);
        chk_cnt++; if (in_data[0] !== 1'b0) $display("FAIL db_early: got %b want 0", in_data[0]); else pass_cnt++;
        step(1);
        chk_cnt++; if (in_data[0] !== 1'b1) $display("FAIL db_rise: got %b want 1", in_data[0]); else pass_cnt++;
        // three-cycle low glitch
        pad_if.pad_in[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (i == 3) pad_if.pad_in[0] = 1'b1;
            exp = (!DbEn && i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            chk_cnt++; if (in_data[0] !== exp) $display("FAIL db_glitch_%0d: got %b want %b", i, in_data[0], exp); else pass_cnt++;
        end
        // lower D mid-count
        pad_if.pad_in[0] = 1'b0;
        step(3);
        exp = DbEn ? 1'b1 : 1'b0;
        chk_cnt++; if (in_data[0] !== exp) $display("FAIL db_dchg_pre: got %b want %b", in_data[0], exp); else pass_cnt++;
        debounce_cycles = 8'd1;
        step(1);
        chk_cnt++; if (in_data[0] !== 1'b0) $display("FAIL db_dchg_post: got %b want 0", in_data[0]); else pass_cnt++;
        chk_cnt++; if (irq !== 1'b0) $display("FAIL db_noirq: got %b want 0", irq); else pass_cnt++;
    endtask

    task automatic test_irq;
        debounce_cycles = 8'd0;
        irq_rise_en = 8'h04; irq_fall_en = 8'h00;
        pad_if.pad_in[2] = 1'b1;
        step(2);
        chk_cnt++; if (irq_pending !== 8'h00) $display("FAIL irq_early: got %h want 00", irq_pending); else pass_cnt++;
        step(1);
        chk_cnt++; if (irq_pending !== 8'h04) $display("FAIL irq_rise: got %h want 04", irq_pending); else pass_cnt++;
        chk_cnt++; if (irq !== 1'b1) $display("FAIL irq_or: got %b want 1", irq); else pass_cnt++;
        irq_clear = 8'h04;
        step(1);
        irq_clear = 8'h00;
        chk_cnt++; if (irq_pending !== 8'h00) $display("FAIL irq_clear: got %h want 00", irq_pending); else pass_cnt++;
        pad_if.pad_in[2] = 1'b0;
        step(5);
        chk_cnt++; if (irq_pending !== 8'h00) $display("FAIL irq_nofall: got %h want 00", irq_pending); else pass_cnt++;
        pad_if.pad_in[2] = 1'b1;
        step(2);
        irq_clear = 8'h04;
        step(1);
        irq_clear = 8'h00;
        chk_cnt++; if (irq_pending !== 8'h04) $display("FAIL irq_set_wins: got %h want 04", irq_pending); else pass_cnt++;
        irq_clear = 8'h04;
        step(1);
        irq_clear = 8'h00; irq_rise_en = 8'h00;
        step(1);
    endtask

    task automatic test_reset_mid;
        debounce_cycles = 8'd4;
        irq_rise_en = 8'h08;
        pad_if.pad_in[3] = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_cnt++; if ({in_data[3], irq} !== 2'b00) $display("FAIL rstmid_clr: got %b want 00", {in_data[3], irq}); else pass_cnt++;
        step(lat(4) - 1);
        chk_cnt++; if (in_data[3] !== 1'b0) $display("FAIL rstmid_early: got %b want 0", in_data[3]); else pass_cnt++;
        step(1);
        chk_cnt++; if (in_data[3] !== 1'b1) $display("FAIL rstmid_rise: got %b want 1", in_data[3]); else pass_cnt++;
        chk_cnt++; if (irq_pending !== 8'h08) $display("FAIL rstmid_irq: got %h want 08", irq_pending); else pass_cnt++;
    endtask

    task automatic test_macro_off_latency;
        debounce_cycles = 8'd200;
        irq_rise_en = 8'h00;
        pad_if.pad_in[6] = 1'b1;
        step(3);
        if (!DbEn) begin
            chk_cnt++; if (in_data[6] !== 1'b1) $display("FAIL nodb_lat: got %b want 1", in_data[6]); else pass_cnt++;
        end else begin
            chk_cnt++; if (in_data[6] !== 1'b0) $display("FAIL db200_hold: got %b want 0", in_data[6]); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_output();
        test_pull();
        test_debounce();
        test_irq();
        test_reset_mid();
        test_macro_off_latency();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
